clock_period_meter: RTL and testbench
=====================================

Name: clock_period_meter

Overview:
- Receive-side counterpart to the team's rollover-driven clock generator.
- Takes a slow, asynchronous derived clock (`i_sig_clk`) and recovers its rising edges as one-cycle pulses on the system clock.
- Measures the period of `i_sig_clk` in `i_clk` cycles and detects a stalled derived clock.
- Delivers each measurement through a valid/ready handshake to a monitor or status register block.

Parameters:
- CNT_WIDTH, 16: width of the period counter and of `o_period`.
- STUCK_LIMIT, 1000: cycles without a rising edge, while measuring, before `o_stuck` asserts. Must be in the range 2 to 2^CNT_WIDTH-1.

Ports:
- i_clk  input  1  system clock; all state is updated on its rising edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_enable  input  1  measurement enable.
- i_sig_clk  input  1  derived clock under measurement; asynchronous to `i_clk`.
- o_rise  output  1  one-cycle pulse per synchronized rising edge of `i_sig_clk`.
- o_period  output  CNT_WIDTH  last accepted period, in `i_clk` cycles.
- o_period_valid  output  1  `o_period` holds an unconsumed measurement.
- i_period_ready  input  1  consumer accepts `o_period`.
- o_stuck  output  1  no rising edge seen for STUCK_LIMIT cycles.
- o_overrun  output  1  sticky: a measurement was dropped because the previous one was still pending.

Behaviour:
- Reset is asynchronous and active-high. While `i_reset` is high:
  - all outputs are 0;
  - synchronizer flops are 0;
  - the counter is 0;
  - the FSM is in IDLE.
- Synchronizer: 2 flops (`sync1`, `sync2`) followed by a history flop `sync3`.
- Rise detect and latency:
  - rise = `sync2` & ~`sync3`, registered into `o_rise`.
  - If `i_sig_clk` goes 0→1 before `i_clk` edge k, `o_rise` is high for exactly the cycle after edge k+2.
  - Total latency is 3 edges.
  - Edge detection runs regardless of `i_enable`.
- Counter `cnt`:
  - In the cycle where `o_rise` = 1, the edge ending that cycle loads `cnt` = 1.
  - Otherwise `cnt` increments, saturating at 2^CNT_WIDTH-1.
  - Result: with successive `o_rise` pulses in cycles t1 and t2, `cnt` = t2-t1 during cycle t2.
- FSM states and transitions:
  - IDLE:
    - `cnt` is held at 0.
    - If `i_enable` = 1 and `o_rise` = 1: go to MEASURE, `cnt` = 1. No period is emitted.
  - MEASURE:
    - On `o_rise`: emit `cnt` as a period (see handshake), `cnt` = 1.
    - If `cnt` == STUCK_LIMIT with no `o_rise`: go to STUCK, set `o_stuck` = 1.
  - STUCK:
    - The counter is frozen.
    - On `o_rise`: go to MEASURE, `cnt` = 1, clear `o_stuck`. No period is emitted, because the interval is invalid.
  - From any state, `i_enable` = 0 → IDLE on the next edge and `o_stuck` clears.
  - A pending `o_period_valid`/`o_period` is kept until accepted; `o_overrun` is kept.
- Handshake:
  - Emit while `o_period_valid` = 0: `o_period` <= `cnt`, `o_period_valid` <= 1.
  - `o_period_valid` & `i_period_ready` at an edge: `o_period_valid` <= 0.
  - `o_period` holds its value while valid.
  - Emit while valid and not accepted in that cycle: the new value is dropped and `o_overrun` <= 1.
  - Emit in the same cycle as accept: the new value is loaded and `o_period_valid` stays 1 (no bubble, no overrun).
  - `o_overrun` clears only on reset.
- Saturation: a period of 2^CNT_WIDTH-1 is reported as that value (reachable only if STUCK_LIMIT equals it).

Optional Feature:
- Macro: CLOCK_PERIOD_METER_DUTY_EN.
- When defined:
  - Adds output port `o_high_time` [CNT_WIDTH].
  - A second counter measures `i_clk` cycles from `o_rise` to the synchronized falling edge (~`sync2` & `sync3`).
  - `o_high_time` is captured alongside `o_period` under the same valid/ready, drop and overrun rules; reset value 0.
  - With no falling edge before the next rise, `o_high_time` = period.
- When undefined: the port and the counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset then enable; `i_sig_clk` square wave with period 8 `i_clk`, `i_period_ready` = 1:
  - first rise → no valid;
  - every later rise → `o_period` = 8, `o_period_valid` pulse, `o_rise` 3 edges after the input edge.
- Period 8, `i_period_ready` held 0:
  - first measurement 8 stays valid;
  - second rise sets `o_overrun` = 1, `o_period` stays 8;
  - after ready = 1, valid drops and `o_overrun` stays 1.
- STUCK_LIMIT = 20; `i_sig_clk` stops after 2 edges:
  - `o_stuck` = 1 exactly when `cnt` reaches 20;
  - next rise clears `o_stuck` with no period emitted;
  - following rise period is correct.
- Ready asserted in the exact cycle of a new emit (period 5 back-to-back): valid stays 1, `o_period` updates to 5, no overrun.
- Assert `i_reset` mid-measurement and mid-pending-valid: all outputs 0 immediately (asynchronous); first rise after release emits nothing.
- With CLOCK_PERIOD_METER_DUTY_EN defined, 3-high/5-low wave: `o_period` = 8, `o_high_time` = 3.

Source files
------------

// File: rtl/clock_period_meter.sv
`timescale 1ns/1ps
// clock_period_meter: recovers rising edges of a slow asynchronous clock and measures its period.
// Define CLOCK_PERIOD_METER_DUTY_EN to also report the high time of each period on o_high_time.
module clock_period_meter #(
    parameter int CNT_WIDTH   = 16,
    parameter int STUCK_LIMIT = 1000
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_enable,
    input  logic                 i_sig_clk,
    output logic                 o_rise,
    output logic [CNT_WIDTH-1:0] o_period,
    output logic                 o_period_valid,
    input  logic                 i_period_ready,
    output logic                 o_stuck,
`ifdef CLOCK_PERIOD_METER_DUTY_EN
    output logic [CNT_WIDTH-1:0] o_high_time,
`endif
    output logic                 o_overrun
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_MEASURE = 2'd1;
    localparam logic [1:0] ST_STUCK   = 2'd2;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = CNT_WIDTH'(STUCK_LIMIT);

    logic                 sync1_q, sync1_d;
    logic                 sync2_q, sync2_d;
    logic                 sync3_q, sync3_d;
    logic                 rise_q, rise_d;
    logic [1:0]           state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 stuck_q, stuck_d;
    logic [CNT_WIDTH-1:0] period_q, period_d;
    logic                 valid_q, valid_d;
    logic                 overrun_q, overrun_d;
    logic                 emit;

`ifdef CLOCK_PERIOD_METER_DUTY_EN
    logic                 fall_q, fall_d;
    logic [CNT_WIDTH-1:0] hcnt_q, hcnt_d;
    logic                 hdone_q, hdone_d;
    logic [CNT_WIDTH-1:0] high_q, high_d;
`endif

    // sync1/sync2 resolve metastability; sync3 is the history bit for edge detection.
    always_comb begin
        sync1_d = i_sig_clk;
        sync2_d = sync1_q;
        sync3_d = sync2_q;
        rise_d  = sync2_q & ~sync3_q;
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stuck_d = stuck_q;
        emit    = 1'b0;
        if (!i_enable) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            stuck_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_d = '0;
                    if (rise_q) begin
                        state_d = ST_MEASURE;
                        cnt_d   = CNT_ONE;
                    end
                end
                ST_MEASURE: begin
                    if (rise_q) begin
                        emit  = 1'b1;
                        cnt_d = CNT_ONE;
                    end else if (cnt_q == CNT_LIMIT) begin
                        state_d = ST_STUCK;
                        stuck_d = 1'b1;
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_STUCK: begin
                    // The interval spanning a stall is meaningless, so restart without emitting.
                    if (rise_q) begin
                        state_d = ST_MEASURE;
                        cnt_d   = CNT_ONE;
                        stuck_d = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    stuck_d = 1'b0;
                end
            endcase
        end
    end

`ifdef CLOCK_PERIOD_METER_DUTY_EN
    // High-time counter runs from each rise and freezes at the first fall after it.
    always_comb begin
        fall_d  = ~sync2_q & sync3_q;
        hcnt_d  = hcnt_q;
        hdone_d = hdone_q;
        if (rise_q) begin
            hcnt_d  = CNT_ONE;
            hdone_d = 1'b0;
        end else if (fall_q) begin
            hdone_d = 1'b1;
        end else if (!hdone_q && hcnt_q != CNT_MAX) begin
            hcnt_d = hcnt_q + CNT_ONE;
        end
    end
`endif

    always_comb begin
        period_d  = period_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
`ifdef CLOCK_PERIOD_METER_DUTY_EN
        high_d    = high_q;
`endif
        if (valid_q && i_period_ready) begin
            valid_d = 1'b0;
        end
        // A same-cycle accept frees the slot, so the new value slips in without a bubble.
        if (emit) begin
            if (!valid_q || i_period_ready) begin
                period_d = cnt_q;
                valid_d  = 1'b1;
`ifdef CLOCK_PERIOD_METER_DUTY_EN
                high_d   = hcnt_q;
`endif
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    // NOTE: non-blocking assignments so every flop samples the pre-edge value of its neighbours.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            sync3_q   <= 1'b0;
            rise_q    <= 1'b0;
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            stuck_q   <= 1'b0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
`ifdef CLOCK_PERIOD_METER_DUTY_EN
            fall_q    <= 1'b0;
            hcnt_q    <= '0;
            hdone_q   <= 1'b0;
            high_q    <= '0;
`endif
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            sync3_q   <= sync3_d;
            rise_q    <= rise_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            stuck_q   <= stuck_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
`ifdef CLOCK_PERIOD_METER_DUTY_EN
            fall_q    <= fall_d;
            hcnt_q    <= hcnt_d;
            hdone_q   <= hdone_d;
            high_q    <= high_d;
`endif
        end
    end

    assign o_rise         = rise_q;
    assign o_period       = period_q;
    assign o_period_valid = valid_q;
    assign o_stuck        = stuck_q;
    assign o_overrun      = overrun_q;
`ifdef CLOCK_PERIOD_METER_DUTY_EN
    assign o_high_time    = high_q;
`endif

endmodule

// File: tb/tb_clock_period_meter.sv
`timescale 1ns/1ps
// Testbench for clock_period_meter: directed phases plus randomized waveforms, each cycle
// compared against a timestamp-based reference model. Honours CLOCK_PERIOD_METER_DUTY_EN.
module tb_clock_period_meter;

    localparam int W     = 16;
    localparam int LIMIT = 20;
    localparam int HSZ   = 16384;

    logic         i_clk = 1'b0;
    logic         i_reset = 1'b1;
    logic         i_enable = 1'b0;
    logic         i_sig_clk = 1'b0;
    logic         i_period_ready = 1'b0;
    logic         o_rise;
    logic [W-1:0] o_period;
    logic         o_period_valid;
    logic         o_stuck;
    logic         o_overrun;
`ifdef CLOCK_PERIOD_METER_DUTY_EN
    logic [W-1:0] o_high_time;
`endif

    clock_period_meter #(.CNT_WIDTH(W), .STUCK_LIMIT(LIMIT)) dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_enable       (i_enable),
        .i_sig_clk      (i_sig_clk),
        .o_rise         (o_rise),
        .o_period       (o_period),
        .o_period_valid (o_period_valid),
        .i_period_ready (i_period_ready),
        .o_stuck        (o_stuck),
`ifdef CLOCK_PERIOD_METER_DUTY_EN
        .o_high_time    (o_high_time),
`endif
        .o_overrun      (o_overrun)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: cycle n is the interval after the n-th rising edge since reset release.
    // hist[e] is the sampled input at edge e; a rise is visible two edges after it is sampled.
    localparam int M_IDLE = 0, M_MEAS = 1, M_STUCK = 2;
    bit hist [0:HSZ-1];
    int n, mode, t_last, t_fall, m_period, m_high;
    bit m_valid, m_overrun, m_rise, m_fall;

    function automatic bit h(input int i);
        return (i < 1 || i >= HSZ) ? 1'b0 : hist[i];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < HSZ; i++) hist[i] = 1'b0;
        n = 0; mode = M_IDLE; t_last = 0; t_fall = -1;
        m_period = 0; m_high = 0; m_valid = 0; m_overrun = 0; m_rise = 0; m_fall = 0;
    endtask

    // Advance the model across the edge that samples inputs (s, e, r).
    task automatic model_step(input logic s, input logic e, input logic r);
        bit emit = 0;
        bit old_v;
        int val = 0, hv = 0;
        if (m_fall && t_fall < 0) t_fall = n;
        if (e) begin
            if (m_rise && mode == M_MEAS) begin
                emit = 1;
                val = n - t_last;
                hv = (t_fall >= 0) ? t_fall - t_last : val;
            end
            if (m_rise) mode = M_MEAS;
            else if (mode == M_MEAS && n - t_last == LIMIT) mode = M_STUCK;
        end else begin
            mode = M_IDLE;
        end
        if (m_rise) begin
            t_last = n;
            t_fall = -1;
        end
        old_v = m_valid;
        if (m_valid && r) m_valid = 0;
        if (emit) begin
            if (!old_v || r) begin
                m_period = val; m_high = hv; m_valid = 1;
            end else begin
                m_overrun = 1;
            end
        end
        n++;
        if (n < HSZ) hist[n] = s;
        m_rise = h(n - 2) && !h(n - 3);
        m_fall = !h(n - 2) && h(n - 3);
    endtask

    task automatic compare_all();
        check("rise",    32'(o_rise),         32'(m_rise));
        check("valid",   32'(o_period_valid), 32'(m_valid));
        check("period",  32'(o_period),       32'(m_period));
        check("stuck",   32'(o_stuck),        32'(mode == M_STUCK));
        check("overrun", 32'(o_overrun),      32'(m_overrun));
`ifdef CLOCK_PERIOD_METER_DUTY_EN
        check("high",    32'(o_high_time),    32'(m_high));
`endif
    endtask

    // Called just after a falling edge: drive inputs for the next rising edge, then compare.
    task automatic tick(input logic s, input logic e, input logic r);
        i_sig_clk = s; i_enable = e; i_period_ready = r;
        model_step(s, e, r);
        @(negedge i_clk);
        compare_all();
    endtask

    int   wave_left = 0;
    logic wave_lvl = 1'b0;

    task automatic wave_next(input int hi, input int lo, output logic s);
        if (wave_left == 0) begin
            wave_lvl = ~wave_lvl;
            wave_left = wave_lvl ? hi : lo;
        end
        wave_left--;
        s = wave_lvl;
    endtask

    task automatic run_wave(input int cycles, input int hi, input int lo, input logic r);
        logic s;
        for (int i = 0; i < cycles; i++) begin
            wave_next(hi, lo, s);
            tick(s, 1'b1, r);
        end
    endtask

    task automatic do_reset();
        #2;
        i_reset = 1'b1; i_sig_clk = 1'b0; i_enable = 1'b0; i_period_ready = 1'b0;
        #1;
        check("rst_rise",    32'(o_rise),         0);
        check("rst_valid",   32'(o_period_valid), 0);
        check("rst_period",  32'(o_period),       0);
        check("rst_stuck",   32'(o_stuck),        0);
        check("rst_overrun", 32'(o_overrun),      0);
        model_reset();
        @(negedge i_clk);
        @(negedge i_clk);
        i_reset = 1'b0;
        wave_lvl = 1'b0; wave_left = 0;
        compare_all();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic s;
        int   guard;
        int   en_off;
        logic r;
        @(negedge i_clk);
        do_reset();

        // Period 8, always ready.
        run_wave(60, 4, 4, 1'b1);
        check("p1_period", 32'(o_period), 8);

        // Ready held low: first value kept, second dropped.
        run_wave(30, 4, 4, 1'b0);
        check("p2_valid",   32'(o_period_valid), 1);
        check("p2_period",  32'(o_period),       8);
        check("p2_overrun", 32'(o_overrun),      1);
        run_wave(10, 4, 4, 1'b1);
        check("p2_overrun_kept", 32'(o_overrun), 1);

        // Stall detection and recovery.
        run_wave(8, 4, 4, 1'b1);
        for (int i = 0; i < 40; i++) tick(1'b0, 1'b1, 1'b1);
        check("p3_stuck", 32'(o_stuck), 1);
        wave_lvl = 1'b0; wave_left = 0;
        run_wave(30, 4, 4, 1'b1);
        check("p3_unstuck", 32'(o_stuck),  0);
        check("p3_period",  32'(o_period), 8);

        // Accept in the exact cycle of a new emit, period 5.
        do_reset();
        guard = 0;
        while (o_period_valid !== 1'b1 && guard < 100) begin
            wave_next(2, 3, s); tick(s, 1'b1, 1'b0); guard++;
        end
        check("p4_wait_valid", 32'(guard < 100), 1);
        guard = 0;
        while (o_rise !== 1'b1 && guard < 20) begin
            wave_next(2, 3, s); tick(s, 1'b1, 1'b0); guard++;
        end
        check("p4_wait_rise", 32'(guard < 20), 1);
        wave_next(2, 3, s); tick(s, 1'b1, 1'b1);
        check("p4_valid",   32'(o_period_valid), 1);
        check("p4_period",  32'(o_period),       5);
        check("p4_overrun", 32'(o_overrun),      0);
        run_wave(60, 2, 3, 1'b1);

        // Randomized waveforms, ready and enable.
        do_reset();
        en_off = 0;
        for (int i = 0; i < 3000; i++) begin
            if (wave_left == 0) begin
                wave_lvl = ~wave_lvl;
                if (wave_lvl) wave_left = int'($urandom_range(1, 10));
                else if ($urandom_range(0, 9) == 0) wave_left = int'($urandom_range(21, 35));
                else wave_left = int'($urandom_range(1, 10));
            end
            wave_left--;
            if (en_off > 0) en_off--;
            else if ($urandom_range(0, 199) == 0) en_off = int'($urandom_range(1, 6));
            r = ($urandom_range(0, 3) == 0);
            tick(wave_lvl, en_off == 0, r);
        end

        // Reset with a pending measurement, then no emit on the first rise.
        wave_lvl = 1'b0; wave_left = 0;
        run_wave(30, 4, 4, 1'b0);
        check("p6_pending", 32'(o_period_valid), 1);
        do_reset();
        guard = 0;
        while (o_rise !== 1'b1 && guard < 30) begin
            wave_next(4, 4, s); tick(s, 1'b1, 1'b1); guard++;
        end
        check("p6_wait_rise", 32'(guard < 30), 1);
        run_wave(3, 4, 4, 1'b1);
        check("p6_no_emit", 32'(o_period_valid), 0);

        // 3-high / 5-low wave.
        do_reset();
        run_wave(60, 3, 5, 1'b1);
        check("p7_period", 32'(o_period), 8);
`ifdef CLOCK_PERIOD_METER_DUTY_EN
        check("p7_high", 32'(o_high_time), 3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
